// File: rtl/fetch_decode_queue_pkg.sv
// Shared constants and helpers for the fetch/decode instruction queue.
// Optional feature macro: IFQ_EXC_EN (per-entry fetch exception code).
// Constants normally come from Constants.v. Defaults are provided here when it is absent.
`ifndef PC_START
`define PC_START 32'h0000_3000
`endif
`ifndef PC_END
`define PC_END 32'h0000_6ffc
`endif
`ifndef EXC_ADEL
`define EXC_ADEL 5'd4
`endif
`ifndef NOP_INSTR
`define NOP_INSTR 32'h0000_0000
`endif

package fetch_decode_queue_pkg;

    localparam logic [31:0] PC_START_ADDR = `PC_START;
    localparam logic [31:0] PC_END_ADDR   = `PC_END;
    localparam logic [4:0]  EXC_ADEL_CODE = `EXC_ADEL;
    localparam logic [4:0]  EXC_NONE      = 5'd0;
    localparam int          PC_W          = 32;
    localparam int          INSTR_W       = 32;
    localparam int          EXC_W         = 5;

    // Fetch exception for a PC: misaligned or outside the instruction memory window.
    function automatic logic [4:0] fetch_exc_code(input logic [31:0] pc);
        logic [4:0] code;
        code = EXC_NONE;
        if ((pc[1:0] != 2'b00) || (pc < PC_START_ADDR) || (pc > PC_END_ADDR)) begin
            code = EXC_ADEL_CODE;
        end
        return code;
    endfunction

endpackage

// File: rtl/fetch_decode_queue_entry_array.sv
// Reset-free entry storage for the fetch/decode queue.
// One synchronous write port and one asynchronous read port; validity is owned by the
// top-level occupancy count, so entries never need clearing.
module fdq_entry_array
    import fetch_decode_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1,
    parameter int W     = 64
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [W-1:0]     rd_data
);

    logic [W-1:0] entry_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] entry_reg;

            // Capture the write data when this slot is the write target.
            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == PTR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Head read is combinational so decode sees the entry the cycle it lands.
    assign rd_data = entry_q[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode.
// Holds up to DEPTH {pc, instr} pairs in order, presents the oldest to decode, and
// back-pressures fetch through in_ready. flush drops everything on a redirect.
// Optional feature macro: IFQ_EXC_EN adds a per-entry exception code and the out_exc port.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter int          PTR_W     = 1,
    parameter logic [31:0] NOP_INSTR = `NOP_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc8,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    input  logic             flush,
`ifdef IFQ_EXC_EN
    output logic [4:0]       out_exc,
`endif
    output logic [PTR_W:0]   count
);

`ifdef IFQ_EXC_EN
    localparam int ENTRY_W = PC_W + INSTR_W + EXC_W;
`else
    localparam int ENTRY_W = PC_W + INSTR_W;
`endif
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             push;
    logic             pop;
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_data;
    logic [31:0]      head_pc;
    logic [31:0]      head_instr;

    // Handshakes: flush suppresses both sides so the in-flight word is dropped.
    always_comb begin
        in_ready  = (count_reg != FULL_COUNT);
        out_valid = (count_reg != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    // Pointer and occupancy update; flush returns the queue to its empty origin.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    // State registers; reset lands in the same state as a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

`ifdef IFQ_EXC_EN
    logic [4:0] in_exc;
    logic [4:0] head_exc;

    // Faulting fetches carry a bubble instead of the fetched word.
    always_comb begin
        in_exc  = fetch_exc_code(in_pc);
        wr_data = {in_exc, in_pc, (in_exc != EXC_NONE) ? NOP_INSTR : in_instr};
    end

    assign head_exc = rd_data[PC_W+INSTR_W +: EXC_W];
    assign out_exc  = out_valid ? head_exc : EXC_NONE;
`else
    assign wr_data = {in_pc, in_instr};
`endif

    fdq_entry_array #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (ENTRY_W)
    ) u_entries (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    assign head_pc    = rd_data[INSTR_W +: PC_W];
    assign head_instr = rd_data[0 +: INSTR_W];

    // Empty queue shows a bubble at the start PC; link address is a wrapping +8.
    always_comb begin
        out_pc    = out_valid ? head_pc : PC_START_ADDR;
        out_instr = out_valid ? head_instr : NOP_INSTR;
        out_pc8   = out_pc + 32'd8;
    end

    assign count = count_reg;

endmodule
